aes_ctr_stream: RTL and testbench

- Parametrised CTR-mode streaming wrapper for the pipelined AES-128 core.
- Generates counter blocks and issues them to the core under credit control.
- Buffers the returned keystream in a FIFO and XORs it with a valid/ready plaintext stream to produce ciphertext. CTR decryption uses the same path.
- Sits between the core and the system data path. The core is attached through the core_* ports.

---
 rtl/aes_ctr_stream_if.sv | 20 ++
 rtl/aes_ctr_stream.sv | 204 ++++++++++++++++++++
 tb/tb_aes_ctr_stream.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_ctr_stream_if.sv
// Plaintext-in / ciphertext-out valid-ready stream pair for the AES-CTR wrapper.
// The slave modport is the wrapper's view. The master modport is the system data path's view.
interface aes_ctr_stream_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_ctr_stream.sv
// Generic single-clock FIFO. The head word is visible combinationally.
// Latency: a pushed word is at the head one cycle later.
// Backpressure: a push while full is dropped and flagged on overflow. A pop while empty is ignored.
module aes_ctr_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop_vld,
    output logic [WIDTH-1:0]       head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign push_ok  = push_vld & ~full;
    assign pop_ok   = pop_vld & (count != '0);
    assign overflow = push_vld & full;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// AES-128 CTR streaming wrapper: issues counter blocks to the core and XORs the buffered keystream with plaintext.
// Latency: one register stage from the plaintext/keystream join to out_data. Throughput is one block per cycle.
// Backpressure: core issue is credit-limited by FIFO space. in_ready follows the keystream supply and out_ready.
module aes_ctr_stream #(
    parameter int CTR_WIDTH    = 32,
    parameter int CORE_LATENCY = 11,
    parameter int FIFO_DEPTH   = 16,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [127:0]         key,
    input  logic [127:0]         iv,
    input  logic [LEN_WIDTH-1:0] num_blocks,
    aes_ctr_stream_if.slave      strm,
    output logic                 busy,
    output logic                 done,
    output logic                 ctr_wrapped,
    output logic                 err_overflow,
    output logic                 core_start,
    output logic [127:0]         core_key,
    input  logic                 core_key_ready,
    output logic                 core_in_valid,
    output logic [127:0]         core_in_block,
    input  logic                 core_out_valid,
    input  logic [127:0]         core_out_block
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = $clog2(CORE_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, KEYWAIT, RUN, DRAIN, FIN} state_t;

    state_t               state;
    logic [127:0]         ctr_blk;
    logic [LEN_WIDTH-1:0] num_q;
    logic [LEN_WIDTH-1:0] issued;
    logic [LEN_WIDTH-1:0] delivered;
    logic [IW-1:0]        inflight;
    logic [CW-1:0]        fifo_count;
    logic [127:0]         fifo_head;
    logic                 fifo_ovf;
    logic [CW:0]          credit_used;
    logic                 issue;
    logic                 ks_vld;
    logic                 fire;
    logic                 run_or_drain;

    // Credit covers blocks already buffered plus those still inside the core.
    assign credit_used   = {1'b0, fifo_count} + (CW+1)'(inflight);
    assign issue         = (state == RUN) && (issued < num_q) &&
                           (credit_used < (CW+1)'(FIFO_DEPTH));
    assign core_in_valid = issue;
    assign core_in_block = ctr_blk;

    // With nothing in flight, any returning block belongs to an abandoned message.
    assign ks_vld        = core_out_valid && (inflight != '0);

    assign run_or_drain  = (state == RUN) || (state == DRAIN);
    assign strm.in_ready = run_or_drain && (fifo_count != '0) &&
                           (!strm.out_valid || strm.out_ready);
    assign fire          = strm.in_valid && strm.in_ready;
    assign busy          = (state != IDLE);

    aes_ctr_fifo #(
        .WIDTH (128),
        .DEPTH (FIFO_DEPTH)
    ) u_ks_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (ks_vld),
        .push_dat (core_out_block),
        .pop_vld  (fire),
        .head_dat (fifo_head),
        .count    (fifo_count),
        .overflow (fifo_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ctr_blk       <= '0;
            num_q         <= '0;
            issued        <= '0;
            delivered     <= '0;
            inflight      <= '0;
            core_key      <= '0;
            core_start    <= 1'b0;
            done          <= 1'b0;
            ctr_wrapped   <= 1'b0;
            err_overflow  <= 1'b0;
            strm.out_valid <= 1'b0;
            strm.out_data  <= '0;
        end else begin
            core_start <= 1'b0;
            done       <= (state == FIN);

            if (issue) begin
                ctr_blk[CTR_WIDTH-1:0] <= ctr_blk[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
                issued                 <= issued + LEN_WIDTH'(1);
                // A later block whose low field is zero means the field rolled over.
                if ((issued != '0) && (ctr_blk[CTR_WIDTH-1:0] == '0)) begin
                    ctr_wrapped <= 1'b1;
                end
            end

            case ({issue, ks_vld})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: ;
            endcase

            if (fifo_ovf) begin
                err_overflow <= 1'b1;
            end

            if (fire) begin
                strm.out_data  <= strm.in_data ^ fifo_head;
                strm.out_valid <= 1'b1;
                delivered      <= delivered + LEN_WIDTH'(1);
            end else if (strm.out_ready) begin
                strm.out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        issued      <= '0;
                        delivered   <= '0;
                        ctr_wrapped <= 1'b0;
                        if (num_blocks != '0) begin
                            core_key   <= key;
                            ctr_blk    <= iv;
                            num_q      <= num_blocks;
                            core_start <= 1'b1;
                            state      <= KEYWAIT;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                KEYWAIT: if (core_key_ready) state <= RUN;
                RUN:     if (issued == num_q) state <= DRAIN;
                DRAIN:   if ((delivered == num_q) && !strm.out_valid) state <= FIN;
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_ctr_stream.sv
// Bench for aes_ctr_stream. A behavioural core returns known AES-128 results for the test vectors.
// For any other key/block pair it returns block ^ key, so that expected values can be worked out by hand.
module tb_aes_ctr_stream;
    localparam int L = 11;
    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C1  = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] C2  = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] ZKS = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [95:0]  UPR = 96'h0123456789abcdef01234567;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic [127:0] iv;
    logic [15:0]  num_blocks;
    logic         busy, done, ctr_wrapped, err_overflow;
    logic         core_start, core_in_valid, core_out_valid;
    logic         core_key_ready;
    logic [127:0] core_key, core_in_block, core_out_block;

    aes_ctr_stream_if strm();

    aes_ctr_stream dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .key            (key),
        .iv             (iv),
        .num_blocks     (num_blocks),
        .strm           (strm),
        .busy           (busy),
        .done           (done),
        .ctr_wrapped    (ctr_wrapped),
        .err_overflow   (err_overflow),
        .core_start     (core_start),
        .core_key       (core_key),
        .core_key_ready (core_key_ready),
        .core_in_valid  (core_in_valid),
        .core_in_block  (core_in_block),
        .core_out_valid (core_out_valid),
        .core_out_block (core_out_block)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] ks_fn(input logic [127:0] k, input logic [127:0] b);
        if (k == K1 && b == IV1)                 return P1 ^ C1;
        if (k == K1 && b == IV1 + 128'd1)        return P2 ^ C2;
        if (k == 128'd0 && b == 128'd0)          return ZKS;
        return b ^ k;
    endfunction

    // Core model. It has fixed latency and is not reset by the wrapper's reset. Key ready drops as soon as start is seen.
    logic [127:0] ck_reg = '0;
    int           kr_cnt = 0;
    logic         kr_reg = 1'b0;
    logic [L-1:0] pv = '0;
    logic [127:0] pb [L];
    assign core_key_ready = kr_reg & ~core_start;
    assign core_out_valid = pv[L-1];
    assign core_out_block = pb[L-1];

    always @(posedge clk) begin
        if (core_start) begin
            ck_reg <= core_key;
            kr_cnt <= 12;
            kr_reg <= 1'b0;
        end else if (kr_cnt > 1) begin
            kr_cnt <= kr_cnt - 1;
        end else if (kr_cnt == 1) begin
            kr_cnt <= 0;
            kr_reg <= 1'b1;
        end
        pv    <= {pv[L-2:0], core_in_valid};
        pb[0] <= ks_fn(ck_reg, core_in_block);
        for (int i = 1; i < L; i++) pb[i] <= pb[i-1];
    end

    // Issue/credit monitor. Outstanding = issued - consumed = inflight + buffered.
    logic [127:0] issue_log [256];
    logic         wrap_log  [256];
    int issue_total = 0, fire_total = 0, max_out = 0, credit_viol = 0;

    always @(negedge clk) begin
        if (reset) begin
            fire_total = issue_total;
        end else begin
            if (core_in_valid) begin
                if (issue_total - fire_total >= 16) credit_viol++;
                issue_log[issue_total % 256] = core_in_block;
                wrap_log[issue_total % 256]  = ctr_wrapped;
                issue_total++;
            end
            if (strm.in_valid && strm.in_ready) fire_total++;
            if (issue_total - fire_total > max_out) max_out = issue_total - fire_total;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    function automatic logic [511:0] outs();
        return {120'b0, busy, done, ctr_wrapped, err_overflow, core_start, core_in_valid,
                strm.in_ready, strm.out_valid, core_key, core_in_block, strm.out_data};
    endfunction

    logic [127:0] pt_buf  [64];
    logic [127:0] exp_buf [64];

    task automatic run_msg(input logic [127:0] k, input logic [127:0] ivv, input int n,
                           input int bp, input int restart_cyc, input int abort_after,
                           input string nm);
        int pi = 0, got = 0, ndone = 0;
        @(posedge clk); #1;
        key = k; iv = ivv; num_blocks = 16'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            start = (cyc == restart_cyc);
            if (start) begin
                key = ~k; iv = ~ivv; num_blocks = 16'd7;
            end
            strm.in_valid  = (pi < n);
            strm.in_data   = (pi < n) ? pt_buf[pi] : '0;
            strm.out_ready = (bp == 0) ? 1'b1 : ((cyc < 40) ? 1'b0 : (cyc % 2 == 0));
            @(negedge clk);
            if (strm.in_valid && strm.in_ready) pi++;
            if (strm.out_valid && strm.out_ready) begin
                check($sformatf("%s_blk%0d", nm, got), strm.out_data, exp_buf[got % 64]);
                got++;
            end
            if (done) ndone++;
            if (abort_after > 0 && got == abort_after) return;
            @(posedge clk); #1;
            if (ndone != 0) break;
        end
        strm.in_valid  = 1'b0;
        strm.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) ndone++;
            @(posedge clk); #1;
        end
        check({nm, "_count"}, 512'(got), 512'(n));
        check({nm, "_done"}, 512'(ndone), 512'd1);
    endtask

    typedef struct packed {
        logic [127:0]       key;
        logic [127:0]       iv;
        logic [7:0]         num;
        logic [3:0][127:0]  pt;
        logic [3:0][127:0]  ex;
    } vec_t;

    vec_t tbl [4];
    int   bases [4];

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        logic [127:0] bkey, biv;
        logic d1, d2, d3, b1, cs_seen;
        reset = 1'b1; start = 1'b0; key = '0; iv = '0; num_blocks = '0;
        strm.in_valid = 1'b0; strm.in_data = '0; strm.out_ready = 1'b1;
        for (int i = 0; i < L; i++) pb[i] = '0;

        for (int i = 0; i < 4; i++) tbl[i] = '0;
        tbl[0].key = K1; tbl[0].iv = IV1; tbl[0].num = 8'd2;
        tbl[0].pt[0] = P1; tbl[0].pt[1] = P2; tbl[0].ex[0] = C1; tbl[0].ex[1] = C2;
        tbl[1].num = 8'd1; tbl[1].ex[0] = ZKS;
        tbl[2].key = 128'hff; tbl[2].iv = {UPR, 32'hfffffffe}; tbl[2].num = 8'd3;
        tbl[2].pt[2] = '1;
        tbl[2].ex[0] = {UPR, 32'hffffff01};
        tbl[2].ex[1] = {UPR, 32'hffffff00};
        tbl[2].ex[2] = {96'hfedcba9876543210fedcba98, 32'hffffff00};
        tbl[3].iv = 128'h10; tbl[3].num = 8'd4;
        tbl[3].pt[0] = 128'h1;    tbl[3].ex[0] = 128'h11;
        tbl[3].pt[1] = 128'h3;    tbl[3].ex[1] = 128'h12;
        tbl[3].pt[2] = 128'hff00; tbl[3].ex[2] = 128'hff12;
        tbl[3].pt[3] = {32'hffffffff, 96'h0};
        tbl[3].ex[3] = {32'hffffffff, 96'h13};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", outs(), '0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pt_buf[j]  = tbl[i].pt[j];
                exp_buf[j] = tbl[i].ex[j];
            end
            bases[i] = issue_total;
            run_msg(tbl[i].key, tbl[i].iv, int'(tbl[i].num), 0, (i == 3) ? 8 : -1, 0,
                    $sformatf("vec%0d", i));
        end
        check("f51_ctr1", 512'(issue_log[(bases[0] + 1) % 256][31:0]), 512'(32'hfcfdff00));
        check("restart_issues", 512'(issue_total - bases[3]), 512'd4);

        for (int j = 0; j < 3; j++) begin
            pt_buf[j]  = '0;
            exp_buf[j] = {UPR, 32'hffffffff + 32'(j)};
        end
        base = issue_total;
        run_msg('0, {UPR, 32'hffffffff}, 3, 0, -1, 0, "wrap");
        check("wrap_ctr0", issue_log[base % 256],       {UPR, 32'hffffffff});
        check("wrap_ctr1", issue_log[(base + 1) % 256], {UPR, 32'h00000000});
        check("wrap_ctr2", issue_log[(base + 2) % 256], {UPR, 32'h00000001});
        check("wrap_after2", 512'(wrap_log[(base + 2) % 256]), 512'd1);
        check("wrap_sticky", 512'(ctr_wrapped), 512'd1);

        @(posedge clk); #1;
        num_blocks = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cs_seen = 1'b0;
        @(negedge clk); d1 = done; b1 = busy; cs_seen |= core_start;
        @(posedge clk); #1;
        @(negedge clk); d2 = done; cs_seen |= core_start;
        @(posedge clk); #1;
        @(negedge clk); d3 = done; cs_seen |= core_start;
        check("zero_busy", 512'(b1), 512'd1);
        check("zero_done_seq", 512'({d1, d2, d3}), 512'(3'b010));
        check("zero_no_core_start", 512'(cs_seen), 512'd0);

        bkey = 128'h000102030405060708090a0b0c0d0e0f;
        biv  = 128'hdeadbeefcafef00d12345678fffffff0;
        for (int j = 0; j < 64; j++) begin
            pt_buf[j]  = {$urandom, $urandom, $urandom, $urandom};
            exp_buf[j] = pt_buf[j] ^ ks_fn(bkey, {biv[127:32], biv[31:0] + 32'(j)});
        end
        run_msg(bkey, biv, 64, 1, -1, 0, "bp");
        check("bp_max_credit", 512'(max_out), 512'd16);
        check("bp_credit_viol", 512'(credit_viol), 512'd0);
        check("bp_overflow", 512'(err_overflow), 512'd0);

        for (int j = 0; j < 10; j++) begin
            pt_buf[j]  = '0;
            exp_buf[j] = 128'h100 + 128'(j);
        end
        run_msg('0, 128'h100, 10, 0, -1, 5, "abort");
        @(posedge clk); #1;
        strm.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset_outs", outs(), '0);
        pt_buf[0]  = '0;
        exp_buf[0] = ZKS;
        run_msg('0, '0, 1, 0, -1, 0, "post_reset");
        check("post_reset_overflow", 512'(err_overflow), 512'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
